pc_update_unit: RTL and testbench

//  Fetch-side consumer of the branch-taken decision (PCsrc) produced by the branch

---
 rtl/pc_update_unit_if.sv | 32 +++
 rtl/pc_update_unit.sv | 114 +++++++++++
 tb/tb_pc_update_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_update_unit_if.sv
// Fetch-side bus of the PC update unit: branch resolution inputs, imem fetch
// handshake and observation outputs. dbg_state exposes the fetch FSM encoding.
interface pc_update_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              branch_valid;
    logic              PCsrc;
    logic [ADDR_W-1:0] branch_target;
    logic              stall;
    // Handshake: a fetch of address pc is transferred on a rising edge where
    // imem_req and imem_ready are both high; imem_req never depends on imem_ready,
    // and a fetch that is killed by a redirect before transfer is simply dropped.
    logic              imem_ready;
    logic              imem_req;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              flush;
    logic              misaligned;
    logic [CNT_W-1:0]  taken_cnt;
    logic [1:0]        dbg_state;

    modport master (
        output branch_valid, PCsrc, branch_target, stall, imem_ready,
        input  imem_req, pc, pc_plus4, flush, misaligned, taken_cnt, dbg_state
    );

    modport slave (
        input  branch_valid, PCsrc, branch_target, stall, imem_ready,
        output imem_req, pc, pc_plus4, flush, misaligned, taken_cnt, dbg_state
    );
endinterface

// File: rtl/pc_update_unit.sv
// Program counter owner: issues fetches to imem, applies taken-branch redirects,
// buffers one redirect while a fetch is outstanding and pulses an IF/ID flush.
module pc_update_unit #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                INSTR_BYTES = 4,
    parameter int                CNT_W       = 16
) (
    input logic              clk,
    input logic              rst,
    pc_update_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              flush_q, flush_d;
    logic              mis_q, mis_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              redirect;
    logic              accept;
    logic [ADDR_W-1:0] aligned_tgt;
    logic [ADDR_W-1:0] pc_inc;

    // A buffered redirect makes any later branch wrong-path, so it is not accepted.
    assign redirect    = bus.branch_valid & bus.PCsrc & ~pend_valid_q & (state_q != ST_IDLE);
    assign accept      = bus.imem_ready & ~bus.stall;
    assign aligned_tgt = {bus.branch_target[ADDR_W-1:2], 2'b00};
    assign pc_inc      = pc_q + ADDR_W'(INSTR_BYTES);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_tgt_d   = pend_tgt_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect) begin
                    pc_d = aligned_tgt;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.imem_ready) begin
                    pc_d = pc_inc;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect && accept) begin
                    pc_d         = aligned_tgt;
                    pend_valid_d = 1'b0;
                    state_d      = ST_FETCH;
                end else if (redirect) begin
                    pend_tgt_d   = aligned_tgt;
                    pend_valid_d = 1'b1;
                end else if (accept) begin
                    pc_d         = pend_valid_q ? pend_tgt_q : pc_inc;
                    pend_valid_d = 1'b0;
                    state_d      = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        flush_d = redirect;
        mis_d   = redirect & (bus.branch_target[1:0] != 2'b00);
        cnt_d   = cnt_q;
        if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= '0;
            flush_q      <= 1'b0;
            mis_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_tgt_q   <= pend_tgt_d;
            flush_q      <= flush_d;
            mis_q        <= mis_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.imem_req   = (state_q != ST_IDLE) & ~bus.stall;
    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_inc;
    assign bus.flush      = flush_q;
    assign bus.misaligned = mis_q;
    assign bus.taken_cnt  = cnt_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_pc_update_unit.sv
// Bench for pc_update_unit: directed scenarios then random traffic, all checked
// against a cycle-level reference model of the fetch/redirect rules.
module tb_pc_update_unit;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_update_unit_if #(.ADDR_W(32), .CNT_W(16)) bus ();
    pc_update_unit_if #(.ADDR_W(32), .CNT_W(2))  bus2 ();

    assign bus2.branch_valid  = bus.branch_valid;
    assign bus2.PCsrc         = bus.PCsrc;
    assign bus2.branch_target = bus.branch_target;
    assign bus2.stall         = bus.stall;
    assign bus2.imem_ready    = bus.imem_ready;

    pc_update_unit #(.ADDR_W(32), .RESET_PC(RPC), .INSTR_BYTES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    pc_update_unit #(.ADDR_W(32), .RESET_PC(RPC), .INSTR_BYTES(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_phase;   // 1: idle cycle pending, 2: running
    bit          m_wait;
    logic [31:0] m_pc;
    logic [31:0] pend_q[$];
    int          m_cnt;
    bit          m_flush, m_mis;
    logic [31:0] exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit bv, input bit ps, input logic [31:0] tgt, input bit st, input bit rdy);
        bus.branch_valid  = bv;
        bus.PCsrc         = ps;
        bus.branch_target = tgt;
        bus.stall         = st;
        bus.imem_ready    = rdy;
    endtask

    task automatic model_reset();
        m_phase = 1;
        m_wait  = 0;
        m_pc    = RPC;
        pend_q.delete();
        m_cnt   = 0;
        m_flush = 0;
        m_mis   = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [31:0] t;
        bit take, acc;
        if (m_phase == 1) begin
            m_phase = 2;
            m_flush = 0;
            m_mis   = 0;
        end else begin
            t    = {bus.branch_target[31:2], 2'b00};
            take = bus.branch_valid && bus.PCsrc && (pend_q.size() == 0);
            acc  = bus.imem_ready && !bus.stall;
            if (!m_wait) begin
                if (take) m_pc = t;
                else if (bus.stall) begin end
                else if (bus.imem_ready) m_pc = m_pc + 32'd4;
                else m_wait = 1;
            end else begin
                if (take && acc) begin
                    m_pc = t;
                    m_wait = 0;
                end else if (take) begin
                    pend_q.push_back(t);
                end else if (acc) begin
                    m_pc = (pend_q.size() != 0) ? pend_q.pop_front() : m_pc + 32'd4;
                    m_wait = 0;
                end
            end
            m_flush = take;
            m_mis   = take && (bus.branch_target[1:0] != 2'b00);
            if (take) m_cnt++;
        end
        exp_q.push_back(m_pc);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_val("imem_req", {63'd0, bus.imem_req}, {63'd0, (m_phase == 2) && !bus.stall});
        check_val("pc_plus4", {32'd0, bus.pc_plus4}, {32'd0, m_pc + 32'd4});
        model_step();
        @(posedge clk);
        #1;
        check_val("pc", {32'd0, bus.pc}, {32'd0, exp_q.pop_front()});
        check_val("flush", {63'd0, bus.flush}, {63'd0, m_flush});
        check_val("misaligned", {63'd0, bus.misaligned}, {63'd0, m_mis});
        check_val("taken_cnt", {48'd0, bus.taken_cnt}, 64'(m_cnt > 65535 ? 65535 : m_cnt));
        check_val("taken_cnt_sat2", {62'd0, bus2.taken_cnt}, 64'(m_cnt > 3 ? 3 : m_cnt));
    endtask

    // Async reset asserted mid-cycle: outputs must clear before any clock edge.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check_val("rst_pc", {32'd0, bus.pc}, {32'd0, RPC});
        check_val("rst_flush", {63'd0, bus.flush}, 64'd0);
        check_val("rst_mis", {63'd0, bus.misaligned}, 64'd0);
        check_val("rst_cnt", {48'd0, bus.taken_cnt}, 64'd0);
        check_val("rst_req", {63'd0, bus.imem_req}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] tgt;
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        pulse_reset();

        // sequential fetch after reset
        drive(0, 0, 32'h0, 0, 1);
        repeat (5) cycle();
        check_val("t1_pc", {32'd0, bus.pc}, 64'h10);

        // taken and not-taken branch in FETCH
        drive(1, 1, 32'h200, 0, 1);
        cycle();
        drive(1, 0, 32'h300, 0, 1);
        cycle();
        check_val("t2_pc", {32'd0, bus.pc}, 64'h204);
        check_val("t2_cnt", {48'd0, bus.taken_cnt}, 64'd1);

        // redirect buffered while waiting for imem
        drive(1, 1, 32'h1C, 0, 1);
        cycle();
        drive(0, 0, 32'h0, 0, 1);
        cycle();
        drive(0, 0, 32'h0, 0, 0);
        cycle();
        drive(1, 1, 32'h400, 0, 0);
        cycle();
        drive(1, 1, 32'h800, 0, 0);
        repeat (2) cycle();
        check_val("t3_hold", {32'd0, bus.pc}, 64'h20);
        drive(0, 0, 32'h0, 0, 1);
        cycle();
        check_val("t3_pc", {32'd0, bus.pc}, 64'h400);

        // misaligned target, redirect beats stall, stall alone
        drive(1, 1, 32'h103, 0, 1);
        cycle();
        check_val("t4_mis_pc", {32'd0, bus.pc}, 64'h100);
        drive(1, 1, 32'h500, 1, 0);
        cycle();
        drive(0, 0, 32'h0, 1, 1);
        repeat (5) cycle();
        check_val("t4_stall_pc", {32'd0, bus.pc}, 64'h500);

        // pc wrap and 2-bit counter saturation
        drive(1, 1, 32'hFFFF_FFFC, 0, 1);
        cycle();
        drive(0, 0, 32'h0, 0, 1);
        cycle();
        check_val("t5_wrap", {32'd0, bus.pc}, 64'h0);
        check_val("t5_sat", {62'd0, bus2.taken_cnt}, 64'd3);

        // reset while WAIT holds a pending redirect
        cycle();
        drive(0, 0, 32'h0, 0, 0);
        cycle();
        drive(1, 1, 32'h600, 0, 0);
        cycle();
        pulse_reset();
        drive(0, 0, 32'h0, 0, 1);
        repeat (4) cycle();
        check_val("t6_pc", {32'd0, bus.pc}, 64'hC);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tgt = $urandom();
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, tgt,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 499) == 0) pulse_reset();
            else cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
